// File: rtl/dcache_mem_responder.sv
// Line-wide main-memory model answering dcache refills and write-backs.
// Takes one request at a time and returns a single response pulse LATENCY cycles after acceptance.
module dcache_mem_responder #(
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [32*LINE_WORDS-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [32*LINE_WORDS-1:0] resp_rdata,
    output logic                    resp_err
);
    localparam int LB    = 32 * LINE_WORDS;
    localparam int OFF   = $clog2(LINE_WORDS * 4);
    localparam int IDX   = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [LB-1:0]      resp_rdata_q;
    logic               write_q;
    logic               err_q;
    logic [IDX-1:0]     idx_q;
    logic [LB-1:0]      wdata_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [LB-1:0]      mem_q [DEPTH_LINES] = '{default: '0};

    logic [IDX-1:0]     req_idx;
    logic               addr_err;
    logic [IDX-1:0]     rd_idx_d;
    logic               rd_zero_d;
    logic               commit;

    assign req_idx = req_addr[OFF+IDX-1:OFF];

    // Offset bits only pick a byte inside the line, so they are intentionally dropped.
    logic unused_offset;
    assign unused_offset = &{1'b0, req_addr[OFF-1:0]};

    generate
        if (OFF + IDX < 32) begin : g_range
            assign addr_err = |req_addr[31:OFF+IDX];
        end else begin : g_full
            assign addr_err = 1'b0;
        end
    endgenerate

    // Single read port: the index comes straight from the request on a direct IDLE->RESP hop.
    assign rd_idx_d  = (state_q == S_IDLE) ? req_idx : idx_q;
    assign rd_zero_d = (state_q == S_IDLE) ? (req_write | addr_err) : (write_q | err_q);
    assign commit    = reset && (state_q == S_RESP) && write_q && !err_q;

    always_ff @(posedge clock) begin
        if (commit) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        idx_q       <= req_idx;
                        err_q       <= addr_err;
                        wdata_q     <= req_wdata;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        if (LATENCY > 1) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= addr_err;
                            resp_rdata_q <= rd_zero_d ? '0 : mem_q[rd_idx_d];
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        resp_rdata_q <= rd_zero_d ? '0 : mem_q[rd_idx_d];
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
endmodule
